// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
// Purpose: bundles the requester handshake and the UART TX link of the
// arbiter so that both sides connect through one port.
// Signals:
//   req_valid[NUM_REQ]   requester i has a byte pending
//   req_data[NUM_REQ*8]  byte of requester i at [8i+7:8i]
//   req_lock[NUM_REQ]    requester i wants to keep ownership after this byte
//   req_ready[NUM_REQ]   one-cycle accept pulse for requester i
//   tx_data[8]           byte handed to the UART TX
//   tx_start             one-cycle launch pulse to the UART TX
//   tx_busy              UART TX busy
// Modports: master = requesters plus UART side, slave = arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_lock;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_start;
  logic                 tx_busy;

  modport master (
    output req_valid, req_data, req_lock, tx_busy,
    input  req_ready, tx_data, tx_start
  );

  modport slave (
    input  req_valid, req_data, req_lock, tx_busy,
    output req_ready, tx_data, tx_start
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Purpose: shares one UART transmitter between several mode controllers.
// Each requester offers one byte at a time; grants are round-robin, and a
// requester may lock the channel to send a multi-byte message without
// interleaving. A UART that never reports busy after a launch is detected,
// the byte is dropped and a sticky error is raised.
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   arb_enable_i   1 allows new grants; a transfer in flight always completes
//   clear_err_i    clears timeout_err_o, wins over a same-cycle set
//   bus            requester handshake and UART TX link (slave modport)
//   grant_id_o     index of the last or current granted requester
//   active_o       high while a transfer is in flight
//   timeout_err_o  sticky: UART did not go busy after a launch
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no transfer; arbitration runs here when enabled and UART idle
// WAIT_BUSY | byte launched, waiting for tx_busy to rise (timeout armed)
// WAIT_DONE | UART is sending, waiting for tx_busy to fall
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arb_enable_i,
  input  logic             clear_err_i,
  uart_tx_arbiter_if.slave bus,
  output logic [2:0]       grant_id_o,
  output logic             active_o,
  output logic             timeout_err_o
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   last_grant_q;
  logic [IDX_W-1:0]   lock_owner_q;
  logic               lock_valid_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_REQ-1:0] req_ready_q;
  logic [7:0]         tx_data_q;
  logic               tx_start_q;
  logic [2:0]         grant_id_q;
  logic               active_q;
  logic               timeout_err_q;

  logic               lock_hold_d;
  logic               sel_found_d;
  logic [IDX_W-1:0]   sel_d;
  logic [7:0]         sel_data_d;

  // Winner selection. A held lock restricts eligibility to the owner even
  // when the owner has nothing pending; otherwise the search starts just
  // after the last grant.
  always_comb begin
    logic [IDX_W-1:0] idx;
    idx         = '0;
    lock_hold_d = lock_valid_q && bus.req_lock[lock_owner_q];
    sel_found_d = 1'b0;
    sel_d       = lock_owner_q;
    if (lock_hold_d) begin
      sel_found_d = bus.req_valid[lock_owner_q];
    end else begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
        if (!sel_found_d && bus.req_valid[idx]) begin
          sel_found_d = 1'b1;
          sel_d       = idx;
        end
      end
    end
    sel_data_d = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_d == IDX_W'(i)) sel_data_d = bus.req_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= LAST_RST;
      lock_owner_q  <= '0;
      lock_valid_q  <= 1'b0;
      cnt_q         <= '0;
      req_ready_q   <= '0;
      tx_data_q     <= 8'h00;
      tx_start_q    <= 1'b0;
      grant_id_q    <= 3'd0;
      active_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      req_ready_q <= '0;
      tx_start_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_enable_i && !bus.tx_busy) begin
            // Owner released its lock: drop it and fall back to round-robin now.
            if (lock_valid_q && !lock_hold_d) lock_valid_q <= 1'b0;
            if (sel_found_d) begin
              tx_data_q          <= sel_data_d;
              tx_start_q         <= 1'b1;
              req_ready_q[sel_d] <= 1'b1;
              grant_id_q         <= 3'(sel_d);
              last_grant_q       <= sel_d;
              lock_valid_q       <= bus.req_lock[sel_d];
              lock_owner_q       <= sel_d;
              cnt_q              <= CNT_LOAD;
              active_q           <= 1'b1;
              state_q            <= WAIT_BUSY;
            end
          end
        end
        WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state_q <= WAIT_DONE;
          end else if (cnt_q == '0) begin
            // The byte is considered consumed; it is not relaunched.
            timeout_err_q <= 1'b1;
            lock_valid_q  <= 1'b0;
            active_q      <= 1'b0;
            state_q       <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy) begin
            active_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          active_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
      if (clear_err_i) timeout_err_q <= 1'b0;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_start   = tx_start_q;
  assign grant_id_o     = grant_id_q;
  assign active_o       = active_q;
  assign timeout_err_o  = timeout_err_q;
endmodule
